// File: rtl/data_processing_block.sv
// rtl/data_processing_block.sv - 8-bit pixel processor, per-beat mode, main+skid output buffer
// Define SATURATE_EN to clamp add-one and gain-x2 results at all-ones instead of wrapping.

module data_processing_block #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid_nxt;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_free;
  logic [DATA_W-1:0] result;

  function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        m);
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   dbl;
    logic [DATA_W-1:0] r;
    sum = {1'b0, d} + {{DATA_W{1'b0}}, 1'b1};
    dbl = {d, 1'b0};
    case (m)
      2'b00:   r = d;
      2'b01:   r = sum[DATA_W-1:0];
      2'b10:   r = ~d;
      default: r = dbl[DATA_W-1:0];
    endcase
`ifdef SATURATE_EN
    // the carry-out bit flags overflow for both add-one and shift-left
    if ((m == 2'b01 && sum[DATA_W]) || (m == 2'b11 && dbl[DATA_W]))
      r = '1;
`endif
    return r;
  endfunction

  assign in_xfer   = valid_in && ready_in;
  assign out_xfer  = main_valid && ready_out;
  assign main_free = !main_valid || out_xfer;
  assign result    = transform(data_in, mode);

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (main_free)
      skid_valid_nxt = skid_valid && in_xfer;
    else if (in_xfer)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_in   <= 1'b1;
    end else begin
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          if (in_xfer)
            skid_data <= result;
        end else if (in_xfer) begin
          main_valid <= 1'b1;
          main_data  <= result;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_data <= result;
      end
      skid_valid <= skid_valid_nxt;
      // registered so ready_in never depends combinationally on ready_out
      ready_in   <= !skid_valid_nxt;
    end
  end

  assign valid_out = main_valid;
  assign data_out  = main_data;

endmodule

// File: tb/tb_data_processing_block.sv
// tb/tb_data_processing_block.sv - directed and random checks against a queue-based reference model

module tb_data_processing_block;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_in;
  logic [1:0] mode;
  logic       valid_out;
  logic       ready_out;
  logic [7:0] data_out;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  bit         last_in_acc;

  data_processing_block #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .mode      (mode),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_fn(input logic [7:0] d, input logic [1:0] m);
    int v;
    case (m)
      2'd0:    v = int'(d);
      2'd1:    v = int'(d) + 1;
      2'd2:    v = 255 - int'(d);
      default: v = int'(d) * 2;
    endcase
`ifdef SATURATE_EN
    if (v > 255) v = 255;
`else
    v = v % 256;
`endif
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("valid_out", {31'd0, valid_out}, {31'd0, exp_q.size() > 0});
    check("ready_in", {31'd0, ready_in}, {31'd0, exp_q.size() < 2});
    if (exp_q.size() > 0)
      check("data_out", {24'd0, data_out}, {24'd0, exp_q[0]});
  endtask

  // one clock: predict transfers from the model, advance the model, then compare
  task automatic step();
    bit in_acc;
    bit out_acc;
    in_acc  = (rst === 1'b1) && valid_in && (exp_q.size() < 2);
    out_acc = (rst === 1'b1) && ready_out && (exp_q.size() > 0);
    if (valid_out === 1'b1 && ready_out)
      out_log.push_back(data_out);
    @(posedge clk);
    if (rst !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_acc) void'(exp_q.pop_front());
      if (in_acc) exp_q.push_back(ref_fn(data_in, mode));
    end
    last_in_acc = in_acc;
    @(negedge clk);
    check_state();
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] m);
    valid_in = 1'b1;
    data_in  = d;
    mode     = m;
    for (int k = 0; k < 50; k++) begin
      step();
      if (last_in_acc) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check(tag, {24'd0, data_out}, {24'd0, exp});
  endtask

  initial begin
    logic [7:0] exp_ovf_add;
    logic [7:0] exp_ovf_dbl;
    logic [7:0] bp_exp[4];
    rst       = 1'b0;
    valid_in  = 1'b0;
    data_in   = 8'h00;
    mode      = 2'b00;
    ready_out = 1'b1;

    @(negedge clk);
    step();
    step();
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);
    rst = 1'b1;
    step();

    // basic modes, one beat each
    send(8'hA5, 2'b00); expect_out("mode00", 8'hA5); valid_in = 1'b0; step();
    send(8'hC2, 2'b01); expect_out("mode01", 8'hC3); valid_in = 1'b0; step();
    send(8'hB3, 2'b10); expect_out("mode10", 8'h4C); valid_in = 1'b0; step();
    send(8'h09, 2'b11); expect_out("mode11", 8'h12); valid_in = 1'b0; step();

`ifdef SATURATE_EN
    exp_ovf_add = 8'hFF;
    exp_ovf_dbl = 8'hFF;
`else
    exp_ovf_add = 8'h00;
    exp_ovf_dbl = 8'h00;
`endif
    send(8'hFF, 2'b01); expect_out("ovf_add", exp_ovf_add); valid_in = 1'b0; step();
    send(8'h80, 2'b11); expect_out("ovf_dbl", exp_ovf_dbl); valid_in = 1'b0; step();

    // backpressure: ready_out low for 4 cycles
    out_log.delete();
    ready_out = 1'b0;
    send(8'h10, 2'b00);
    send(8'h20, 2'b00);
    check("bp_ready_in_low", {31'd0, ready_in}, 32'd0);
    data_in = 8'h30;
    step();
    step();
    check("bp_hold", {24'd0, data_out}, 32'h10);
    ready_out = 1'b1;
    send(8'h30, 2'b00);
    send(8'h40, 2'b00);
    valid_in = 1'b0;
    repeat (4) step();
    bp_exp = '{8'h10, 8'h20, 8'h30, 8'h40};
    check("bp_count", out_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      check("bp_order", {24'd0, out_log[i]}, {24'd0, bp_exp[i]});

    // back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i);
      mode     = 2'b01;
      step();
      check("tp_ready_in", {31'd0, ready_in}, 32'd1);
      check("tp_data", {24'd0, data_out}, i + 1);
    end
    valid_in = 1'b0;
    step();

    // mode change mid-stream with backpressure
    out_log.delete();
    ready_out = 1'b0;
    send(8'h00, 2'b10);
    send(8'h00, 2'b00);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (3) step();
    check("mc_count", out_log.size(), 32'd2);
    if (out_log.size() == 2) begin
      check("mc_first", {24'd0, out_log[0]}, 32'hFF);
      check("mc_second", {24'd0, out_log[1]}, 32'h00);
    end

    // reset with both buffers full
    ready_out = 1'b0;
    send(8'h55, 2'b00);
    send(8'h66, 2'b01);
    valid_in = 1'b1;
    data_in  = 8'h77;
    rst      = 1'b0;
    step();
    check("mrst_valid_out", {31'd0, valid_out}, 32'd0);
    check("mrst_data_out", {24'd0, data_out}, 32'd0);
    check("mrst_ready_in", {31'd0, ready_in}, 32'd1);
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    out_log.delete();
    repeat (3) step();
    check("mrst_no_ghost", out_log.size(), 32'd0);

    // random traffic; source holds a beat until it is taken
    for (int i = 0; i < 400; i++) begin
      if (!valid_in || last_in_acc) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = 8'($urandom);
        mode     = 2'($urandom);
      end
      ready_out = ($urandom_range(0, 2) != 0);
      step();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/data_processing_block.md
Name: data_processing_block

Overview:
- Single-channel 8-bit pixel processor with valid/ready streaming on both sides.
- Each accepted pixel is transformed by a per-beat mode (bypass, increment, invert, double) and presented on the output one cycle later.
- A 2-entry output buffer (main + skid) gives full throughput and a registered ready_in.
- Sits between a pixel source and a downstream consumer in the image path.

Parameters:
- DATA_W, 8, pixel width in bits; all arithmetic is at this width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- valid_in  in  1  source presents a pixel
- ready_in  out  1  block can accept a pixel this cycle (registered)
- data_in  in  DATA_W  input pixel
- mode  in  2  operation for this beat; sampled together with data_in
- valid_out  out  1  data_out holds a result
- ready_out  in  1  consumer accepts the result this cycle
- data_out  out  DATA_W  processed pixel

Behaviour:
- Input transfer: valid_in && ready_in on a rising edge. Output transfer: valid_out && ready_out on a rising edge.
- Mode function, combinational on data_in/mode at transfer:
  - 00: bypass, out = d.
  - 01: add one, out = d + 1.
  - 10: invert, out = ~d.
  - 11: gain x2, out = d << 1.
  - Add and gain overflow handling follow the Optional Feature section.
- Mode is captured per beat. A change of mode never alters results already buffered.
- Storage: main register (drives data_out/valid_out) plus skid register, each with its own valid flag.
- ready_in = NOT skid_valid, registered.
- Latency: a pixel accepted at edge N is on data_out with valid_out=1 after edge N, i.e. one cycle.
- Throughput: 1 pixel/cycle while ready_out=1.
- Update rules per edge, evaluated with pre-edge state:
  - Main empty, or main transferring out this edge: main loads skid if skid_valid, else the new input if an input transfer occurs.
  - When skid moves to main, a simultaneous input goes into skid.
  - Main full and not transferring: a new input goes into skid.
  - Skid cleared when it moves to main and no input enters it.
- Ordering is strictly FIFO. No pixel is dropped or duplicated.
- While valid_out=1 and ready_out=0, data_out holds stable.
- ready_in falls the cycle after skid fills, and rises the cycle after skid drains.
- valid_in with ready_in=0 has no effect. Source must hold data_in/mode until transfer.
- Reset (rst=0 at an edge): valid_out=0, data_out=0, skid_valid=0, ready_in=1. Buffered data is discarded, including mid-stream. Inputs are ignored on the reset edge.
- Both buffers full with ready_out=0: ready_in=0, state frozen.

Optional Feature:
- Macro SATURATE_EN.
- Defined: modes 01 and 11 saturate at all-ones (FF+1=FF; 80x2=FF; FF x2=FF).
- Undefined: results wrap modulo 2^DATA_W (FF+1=00; 80x2=00; C1x2=82).
- Modes 00 and 10 are identical in both builds.

Test Plan:
- Basic modes, ready_out=1, one beat each after reset release: (00,A5)->A5; (01,C2)->C3; (10,B3)->4C; (11,09)->12. Each valid_out is 1 cycle after acceptance.
- Overflow: (01,FF) and (11,80) -> FF,FF with SATURATE_EN; 00,00 without.
- Backpressure: stream 10,20,30,40 in mode 00 with ready_out=0 for 4 cycles. ready_in drops after 2 beats accepted; data_out holds 10. Release ready_out -> 10,20,30,40 in order, no loss or duplication.
- Back-to-back throughput: 8 beats, valid_in and ready_out held 1, mode 01 on 00..07 -> 01..08 on consecutive cycles, ready_in stays 1.
- Mode change mid-stream: (10,00) then (00,00) with ready_out=0 for 2 cycles -> outputs FF then 00.
- Reset mid-operation: both buffers full, assert rst=0 one edge -> valid_out=0, data_out=00, ready_in=1. Buffered pixels never appear.
